mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port, synchronous-read program/data RAM between the CPU datapath (port 0: fetch/operand/store traffic) and a second requester (port 1: boot loader / debug access). It sits between the requesters and the RAM and issues at most one RAM access per cycle. Contested cycles are resolved round-robin, with an optional bounded burst lock for port 1. Read data is returned through a latency-matched tag pipeline so each read result goes only to the port that issued it.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, synchronous-read RAM between two
//            requesters. Port 0 is the CPU datapath, port 1 is the boot
//            loader / debug requester. At most one RAM access is issued per
//            cycle. Contested cycles are resolved round-robin, with an
//            optional bounded burst lock for port 1. Read data is steered
//            back to the issuing port through a latency-matched tag pipeline.
//
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            req0/we0/addr0/wdata0 - port 0 request, write enable, address, data
//            gnt0                - port 0 granted this cycle (combinational)
//            rvalid0/rdata0      - port 0 read data valid / read data
//            req1..rdata1        - same set for port 1
//            lock1               - port 1 asks for back-to-back grants
//            ram_wren/ram_addr/ram_data - RAM command outputs
//            ram_q               - RAM read data, RD_LAT cycles after address
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  // port 0
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // port 1
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  input  logic          lock1,
  // RAM side
  output logic          ram_wren,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

  // Registered arbitration state
  logic        r_last_owner;   // port that received the most recent grant
  logic [7:0]  r_burst_cnt;    // consecutive locked port-1 grants

  // Read tag pipeline: one {valid, port} entry per cycle of RAM latency
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_port;

  // Combinational arbitration results
  logic w_burst_hold;
  logic w_gnt0;
  logic w_gnt1;
  logic w_tag_in_vld;
  logic w_tag_in_port;

  // --------------------------------------------------------------------------
  // Grant decision. Grants are suppressed while reset is asserted so nothing
  // reaches the RAM during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_burst_hold = lock1 && r_last_owner && (r_burst_cnt < c_max_burst);
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        // Port 1 keeps the RAM while its burst is live; otherwise the
        // port that did not win last time gets it.
        if (w_burst_hold || !r_last_owner) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // --------------------------------------------------------------------------
  // RAM command mux. Idle cycles present port 0's address/data with the
  // write enable held low.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr = addr0;
    ram_data = wdata0;
    ram_wren = 1'b0;
    if (w_gnt1) begin
      ram_addr = addr1;
      ram_data = wdata1;
      ram_wren = we1;
    end else if (w_gnt0) begin
      ram_wren = we0;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin owner and burst counter. Reset owner is port 1 so port 0
  // wins the first contest.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= 1'b1;
      r_burst_cnt  <= 8'd0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_owner <= w_gnt1;
      end
      if (!lock1 || w_gnt0) begin
        r_burst_cnt <= 8'd0;
      end else if (w_gnt1 && (r_burst_cnt < c_max_burst)) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline. Writes enter as invalid bubbles so the pipeline stays in
  // lock-step with the RAM read latency.
  // --------------------------------------------------------------------------
  assign w_tag_in_vld  = (w_gnt0 && !we0) || (w_gnt1 && !we1);
  assign w_tag_in_port = w_gnt1;

  generate
    if (RD_LAT == 1) begin : g_tag_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tag_vld  <= '0;
          r_tag_port <= '0;
        end else begin
          r_tag_vld  <= w_tag_in_vld;
          r_tag_port <= w_tag_in_port;
        end
      end
    end else begin : g_tag_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tag_vld  <= '0;
          r_tag_port <= '0;
        end else begin
          r_tag_vld  <= {r_tag_vld[RD_LAT-2:0],  w_tag_in_vld};
          r_tag_port <= {r_tag_port[RD_LAT-2:0], w_tag_in_port};
        end
      end
    end
  endgenerate

  // Tail entry qualifies the RAM output for exactly one port.
  assign rvalid0 = r_tag_vld[RD_LAT-1] && !r_tag_port[RD_LAT-1];
  assign rvalid1 = r_tag_vld[RD_LAT-1] &&  r_tag_port[RD_LAT-1];
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A behavioural RAM sits on
//            the RAM port; a reference model tracks ownership, burst length
//            and outstanding reads, and every cycle's grants, RAM command and
//            read returns are compared against it. Directed sequences are
//            followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int RD_LAT    = 3;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .lock1(lock1),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with RD_LAT cycles of read latency
  logic [DW-1:0] ram [256];
  logic [DW-1:0] q_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_wren) ram[ram_addr] <= ram_data;
    q_pipe[0] <= ram[ram_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_q = q_pipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           sb [$];
  logic [DW-1:0] ref_mem [256];
  logic          m_last;
  int            m_cnt;
  int            cyc;
  int            n_vec;
  int            n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then at the falling
  // edge predict and compare everything the DUT shows for that cycle.
  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic lk, output logic g0, output logic g1);
    logic          e0, e1, ev0, ev1, ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erd;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = lk;
    @(negedge clk);

    e0 = 1'b0; e1 = 1'b0;
    if (r) begin
      sb.delete();
      m_last = 1'b1;
      m_cnt  = 0;
    end else if (q0 && q1) begin
      if (lk && m_last && m_cnt < MAX_BURST) e1 = 1'b1;
      else if (m_last)                       e0 = 1'b1;
      else                                   e1 = 1'b1;
    end else begin
      e0 = q0;
      e1 = q1;
    end

    ewr = e1 ? w1 : (e0 ? w0 : 1'b0);
    ea  = e1 ? a1 : a0;
    ed  = e1 ? d1 : d0;
    check_val("gnt0", 32'(gnt0), 32'(e0));
    check_val("gnt1", 32'(gnt1), 32'(e1));
    check_val("ram_wren", 32'(ram_wren), 32'(ewr));
    check_val("ram_addr", 32'(ram_addr), 32'(ea));
    check_val("ram_data", 32'(ram_data), 32'(ed));

    ev0 = 1'b0; ev1 = 1'b0; erd = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].port) ev1 = 1'b1; else ev0 = 1'b1;
      erd = sb[0].data;
      void'(sb.pop_front());
    end
    check_val("rvalid0", 32'(rvalid0), 32'(ev0));
    check_val("rvalid1", 32'(rvalid1), 32'(ev1));
    if (ev0) check_val("rdata0", 32'(rdata0), 32'(erd));
    if (ev1) check_val("rdata1", 32'(rdata1), 32'(erd));

    if (!r) begin
      if (e0 || e1) begin
        m_last = e1;
        if (!ewr) sb.push_back('{due: cyc + RD_LAT, port: e1, data: ref_mem[ea]});
        else      ref_mem[ea] = ed;
      end
      if (!lk || e0)                    m_cnt = 0;
      else if (e1 && m_cnt < MAX_BURST) m_cnt++;
    end
    g0 = gnt0;
    g1 = gnt1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  logic          g0, g1;
  logic          p0, pw0, p1, pw1, lk;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;
  logic          burst_pat [12];

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_last = 1'b1; m_cnt = 0;
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    for (int i = 0; i < RD_LAT; i++) q_pipe[i] = '0;

    // Reset: requests present while rst is high must not be granted
    step(1, 1, 0, 8'h05, 8'h00, 1, 1, 8'h06, 8'h77, 0, g0, g1);
    step(1, 1, 0, 8'h05, 8'h00, 1, 1, 8'h06, 8'h77, 0, g0, g1);

    // Read launched, then reset next cycle: the read must never return
    step(0, 1, 0, 8'h07, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    // Alternation right after reset: port 0 wins the first contest
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 0, g0, g1);
      check_val("alt_seq", 32'(g1), 32'(i % 2));
    end
    for (int i = 0; i < RD_LAT; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    // Single read
    preload(8'h10, 8'h5A);
    step(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    for (int i = 0; i < RD_LAT + 1; i++) begin
      step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
      if (i == RD_LAT - 1) check_val("single_rd", 32'(rdata0), 32'h5A);
    end

    // Port 1 write then port 0 read of the same address
    step(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hA5, 0, g0, g1);
    step(0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    for (int i = 0; i < RD_LAT + 1; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    // Back-to-back reads from alternating ports
    preload(8'h01, 8'h11); preload(8'h02, 8'h22); preload(8'h03, 8'h33);
    step(0, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, g0, g1);
    step(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    for (int i = 0; i < RD_LAT + 1; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    // Burst lock: port 1 first saturates its burst alone, then contention
    for (int i = 0; i < MAX_BURST; i++) step(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00, 1, g0, g1);
    burst_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00, 1, g0, g1);
      check_val("burst_seq", 32'(g1), 32'(burst_pat[i]));
    end
    for (int i = 0; i < RD_LAT; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    // Randomized traffic; each requester holds its command until granted
    p0 = 1'b0; p1 = 1'b0; pw0 = 1'b0; pw1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1'b1; pw0 = ($urandom_range(0, 2) == 0);
        pa0 = 8'($urandom_range(0, 15)); pd0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1'b1; pw1 = ($urandom_range(0, 2) == 0);
        pa1 = 8'($urandom_range(0, 15)); pd1 = 8'($urandom);
      end
      lk = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 199) == 0), p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, lk, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    for (int i = 0; i < RD_LAT + 1; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
